// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: issues one aligned fetch per cycle and handles stalls, I-cache misses and redirects.
// Optional direct-mapped BTB prediction is enabled with `define FETCH_BTB_EN.
module fetch_pc_gen #(
    parameter int                    ADR_WIDTH    = 32,
    parameter int                    RETURN_BYTES = 4,
    parameter logic [ADR_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int                    BTB_ENTRIES  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [ADR_WIDTH-1:0] redirect_adr,
    output logic [ADR_WIDTH-1:0] address,
    output logic                 req_valid,
    output logic [ADR_WIDTH-1:0] predicted_next_adr,
    output logic                 branch_jump,
    input  logic                 data_valid,
    input  logic                 cache_miss,
    input  logic [ADR_WIDTH-1:0] cache_adr_out,
    input  logic                 btb_upd_valid,
    input  logic [ADR_WIDTH-1:0] btb_upd_pc,
    input  logic [ADR_WIDTH-1:0] btb_upd_target
);

    localparam int                   OFF_W      = $clog2(RETURN_BYTES);
    localparam logic [ADR_WIDTH-1:0] STEP       = ADR_WIDTH'(RETURN_BYTES);
    localparam logic [ADR_WIDTH-1:0] ALIGN_MASK = ~(STEP - ADR_WIDTH'(1));

    typedef enum logic [1:0] {
        S_RUN,
        S_MISS,
        S_MISS_REDIR
    } state_t;

    state_t                 state_q;
    logic [ADR_WIDTH-1:0]   npc_q;
    logic [ADR_WIDTH-1:0]   address_q;
    logic                   req_valid_q;
    logic [ADR_WIDTH-1:0]   pred_q;
    logic                   branch_jump_q;

    logic [ADR_WIDTH-1:0]   seq_adr_d;
    logic [ADR_WIDTH-1:0]   pred_adr_d;
    logic [ADR_WIDTH-1:0]   redir_adr_d;
    logic                   btb_hit_d;
    logic                   refill_hit_d;

    assign seq_adr_d    = npc_q + STEP;
    assign redir_adr_d  = redirect_adr & ALIGN_MASK;
    assign refill_hit_d = data_valid && (cache_adr_out == npc_q);

`ifdef FETCH_BTB_EN
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADR_WIDTH - OFF_W - IDX_W;

    logic [BTB_ENTRIES-1:0] btb_vld_q;
    logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
    logic [ADR_WIDTH-1:0]   btb_tgt_q [BTB_ENTRIES];
    logic [IDX_W-1:0]       lk_idx_d;
    logic [IDX_W-1:0]       upd_idx_d;
    logic                   unused_btb_pc;

    assign lk_idx_d      = npc_q[OFF_W +: IDX_W];
    assign upd_idx_d     = btb_upd_pc[OFF_W +: IDX_W];
    assign unused_btb_pc = ^btb_upd_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_vld_q <= '0;
        end else if (btb_upd_valid) begin
            btb_vld_q[upd_idx_d] <= 1'b1;
        end
    end

    // Tag/target storage carries no reset; the valid bits alone qualify a hit.
    always_ff @(posedge clk) begin
        if (btb_upd_valid) begin
            btb_tag_q[upd_idx_d] <= btb_upd_pc[ADR_WIDTH-1 -: TAG_W];
            btb_tgt_q[upd_idx_d] <= btb_upd_target & ALIGN_MASK;
        end
    end

    assign btb_hit_d  = btb_vld_q[lk_idx_d] &&
                        (btb_tag_q[lk_idx_d] == npc_q[ADR_WIDTH-1 -: TAG_W]);
    assign pred_adr_d = btb_hit_d ? btb_tgt_q[lk_idx_d] : seq_adr_d;
`else
    logic unused_btb;

    assign unused_btb = ^{btb_upd_valid, btb_upd_pc, btb_upd_target};
    assign btb_hit_d  = 1'b0;
    assign pred_adr_d = seq_adr_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_RUN;
            npc_q         <= RESET_VECTOR;
            address_q     <= RESET_VECTOR;
            req_valid_q   <= 1'b0;
            pred_q        <= '0;
            branch_jump_q <= 1'b0;
        end else begin
            req_valid_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (redirect_valid) begin
                        npc_q <= redir_adr_d;
                    end else if (cache_miss) begin
                        // The request issued on this edge would be dropped by the blocked cache.
                        npc_q   <= cache_adr_out;
                        state_q <= S_MISS;
                    end else if (!stall) begin
                        address_q     <= npc_q;
                        req_valid_q   <= 1'b1;
                        pred_q        <= pred_adr_d;
                        branch_jump_q <= btb_hit_d;
                        npc_q         <= pred_adr_d;
                    end
                end
                S_MISS: begin
                    // A redirect coinciding with refill completion has nothing left to wait for.
                    if (redirect_valid) begin
                        npc_q   <= redir_adr_d;
                        state_q <= refill_hit_d ? S_RUN : S_MISS_REDIR;
                    end else if (refill_hit_d) begin
                        npc_q   <= pred_adr_d;
                        state_q <= S_RUN;
                    end
                end
                S_MISS_REDIR: begin
                    if (redirect_valid) begin
                        npc_q <= redir_adr_d;
                    end
                    if (data_valid) begin
                        state_q <= S_RUN;
                    end
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    assign address            = address_q;
    assign req_valid          = req_valid_q;
    assign predicted_next_adr = pred_q;
    assign branch_jump        = branch_jump_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: sequential issue, stall, miss/refill, redirects, wrap, BTB and reset.
module tb_fetch_pc_gen;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_adr = '0;
    logic [AW-1:0] address;
    logic          req_valid;
    logic [AW-1:0] predicted_next_adr;
    logic          branch_jump;
    logic          data_valid = 1'b0;
    logic          cache_miss = 1'b0;
    logic [AW-1:0] cache_adr_out = '0;
    logic          btb_upd_valid = 1'b0;
    logic [AW-1:0] btb_upd_pc = '0;
    logic [AW-1:0] btb_upd_target = '0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_pc_gen #(
        .ADR_WIDTH    (AW),
        .RETURN_BYTES (4),
        .RESET_VECTOR (32'h0),
        .BTB_ENTRIES  (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .redirect_valid     (redirect_valid),
        .redirect_adr       (redirect_adr),
        .address            (address),
        .req_valid          (req_valid),
        .predicted_next_adr (predicted_next_adr),
        .branch_jump        (branch_jump),
        .data_valid         (data_valid),
        .cache_miss         (cache_miss),
        .cache_adr_out      (cache_adr_out),
        .btb_upd_valid      (btb_upd_valid),
        .btb_upd_pc         (btb_upd_pc),
        .btb_upd_target     (btb_upd_target)
    );

    task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic exp_issue(input string tag, input logic [AW-1:0] adr, input logic [AW-1:0] pred,
                             input logic bj);
        chk({tag, "_rv"},   AW'(req_valid),   AW'(1'b1));
        chk({tag, "_adr"},  address,            adr);
        chk({tag, "_pred"}, predicted_next_adr, pred);
        chk({tag, "_bj"},   AW'(branch_jump),   AW'(bj));
    endtask

    task automatic exp_idle(input string tag);
        chk({tag, "_rv"}, AW'(req_valid), AW'(1'b0));
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_adr",  address,                 32'h0);
        chk("rst_rv",   AW'(req_valid),          32'h0);
        chk("rst_pred", predicted_next_adr,      32'h0);
        chk("rst_bj",   AW'(branch_jump),        32'h0);
        rst = 1'b0;

        step(); exp_issue("seq0", 32'h0, 32'h4, 1'b0);
        step(); exp_issue("seq1", 32'h4, 32'h8, 1'b0);
        step(); exp_issue("seq2", 32'h8, 32'hC, 1'b0);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_idle("stall");
            chk("stall_adr", address, 32'h8);
        end
        stall = 1'b0;
        step(); exp_issue("post_stall", 32'hC, 32'h10, 1'b0);
        step(); exp_issue("issue10", 32'h10, 32'h14, 1'b0);

        // Miss on 0x10; a refill for a different address must not release the park.
        cache_miss = 1'b1; cache_adr_out = 32'h10;
        step(); cache_miss = 1'b0; exp_idle("miss0");
        step(); exp_idle("miss1");
        data_valid = 1'b1; cache_adr_out = 32'h40;
        step(); data_valid = 1'b0; exp_idle("miss_wrong_dv");
        step(); exp_idle("miss3");
        step(); exp_idle("miss4");
        step(); exp_idle("miss5");
        data_valid = 1'b1; cache_adr_out = 32'h10;
        step(); data_valid = 1'b0; exp_idle("refill_edge");
        step(); exp_issue("after_refill", 32'h14, 32'h18, 1'b0);
        step(); exp_issue("issue18", 32'h18, 32'h1C, 1'b0);

        // Miss on 0x18, then an unaligned redirect while parked.
        cache_miss = 1'b1; cache_adr_out = 32'h18;
        step(); cache_miss = 1'b0; exp_idle("miss18");
        redirect_valid = 1'b1; redirect_adr = 32'h203;
        step(); redirect_valid = 1'b0; exp_idle("miss_redir0");
        step(); exp_idle("miss_redir1");
        step(); exp_idle("miss_redir2");
        data_valid = 1'b1; cache_adr_out = 32'h18;
        step(); data_valid = 1'b0; exp_idle("redir_refill");
        step(); exp_issue("redir_issue", 32'h200, 32'h204, 1'b0);

        // Redirect outranks a simultaneous miss.
        redirect_valid = 1'b1; redirect_adr = 32'h40;
        cache_miss = 1'b1; cache_adr_out = 32'h200;
        step(); redirect_valid = 1'b0; cache_miss = 1'b0; exp_idle("redir_vs_miss");
        step(); exp_issue("redir_win", 32'h40, 32'h44, 1'b0);

        // Wrap from the top aligned address to zero.
        redirect_valid = 1'b1; redirect_adr = 32'hFFFF_FFFE;
        step(); redirect_valid = 1'b0; exp_idle("wrap_redir");
        step(); exp_issue("wrap_top", 32'hFFFF_FFFC, 32'h0, 1'b0);
        step(); exp_issue("wrap_zero", 32'h0, 32'h4, 1'b0);

        // BTB: learn 0x8 -> 0x100, then refetch 0x8.
        btb_upd_valid = 1'b1; btb_upd_pc = 32'h8; btb_upd_target = 32'h100;
        redirect_valid = 1'b1; redirect_adr = 32'h8;
        step(); btb_upd_valid = 1'b0; redirect_valid = 1'b0; exp_idle("btb_redir");
`ifdef FETCH_BTB_EN
        step(); exp_issue("btb_hit", 32'h8, 32'h100, 1'b1);
        step(); exp_issue("btb_target", 32'h100, 32'h104, 1'b0);
`else
        step(); exp_issue("btb_off", 32'h8, 32'hC, 1'b0);
        step(); exp_issue("btb_off_next", 32'hC, 32'h10, 1'b0);
`endif

        // Asynchronous reset in the middle of a miss.
        cache_miss = 1'b1; cache_adr_out = 32'h104;
        step(); cache_miss = 1'b0; exp_idle("pre_rst_miss");
        #2 rst = 1'b1;
        #1;
        chk("async_rst_adr",  address,            32'h0);
        chk("async_rst_rv",   AW'(req_valid),     32'h0);
        chk("async_rst_pred", predicted_next_adr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(); exp_issue("rst_reissue", 32'h0, 32'h4, 1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
